uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
// Bytes are pushed with wr_en and stored in a circular buffer. A four-state
// handshake FSM hands them one at a time to a downstream UART whose busy
// flag runs on a different clock. At most one byte is in flight at a time.
// The FSM drops send in ACK and DONE so the downstream start latch can re-arm.

module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_xtal,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          uart_busy,
    output logic          send,
    output logic [7:0]    DataOut,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          busy_meta;
    logic          busy_s;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop;
    logic          push;

    // Flags come from the registered count, so they settle one cycle after a push or pop.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A pop starts a transfer. A simultaneous pop frees a slot, so a write while full still lands.
    assign pop  = (state == IDLE) && !empty && !busy_s && !clr;
    assign push = wr_en && !clr && (!full || pop);

    // send is decoded straight from the state, so reset drops it without waiting for a clock.
    assign send = (state == REQ);

    // Two-flop synchroniser for the busy flag coming from the UART clock domain.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= uart_busy;
            busy_s    <= busy_meta;
        end
    end

    // Storage array has no reset; a slot is only read after it has been written.
    always_ff @(posedge clk_xtal) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy count and the sticky overflow flag. A flush clears all of them.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Output byte register. It is loaded on a pop and held through the handshake and across a flush.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            DataOut <= 8'h00;
        end else if (pop) begin
            DataOut <= mem[rd_ptr];
        end
    end

    // Handshake next-state logic: IDLE -> REQ -> ACK -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = REQ;
            REQ:     if (busy_s) state_nxt = ACK;
            ACK:     if (!busy_s) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. A flush overrides any transition.
    always_ff @(posedge clk_xtal or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// Inputs are driven and outputs are sampled on the falling clock edge.
// A small UART responder task serves each send request.

module tb_uart_tx_fifo;

    logic       clk_xtal;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       uart_busy;
    logic       send;
    logic [7:0] DataOut;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic send_prev = 1'b0;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk_xtal  (clk_xtal),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .uart_busy (uart_busy),
        .send      (send),
        .DataOut   (DataOut),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk_xtal = 1'b0;
        forever #5 clk_xtal = ~clk_xtal;
    end

    // Counts rising edges of send, so missed or duplicated requests show up.
    always @(negedge clk_xtal) begin
        send_prev <= send;
        if (send && !send_prev) pulses <= pulses + 1;
    end

    // Stops a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] data);
        wr_en   = wr;
        wr_data = data;
        @(negedge clk_xtal);
    endtask

    // UART responder. It waits for send, checks the byte, raises busy,
    // waits for send to drop, then releases busy.
    task automatic serveOne(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (!send && n < 40) begin
            @(negedge clk_xtal);
            n++;
        end
        checkOutput({tag, "_send"}, {31'd0, send}, 32'd1);
        checkOutput({tag, "_data"}, {24'd0, DataOut}, {24'd0, exp});
        repeat (2) @(negedge clk_xtal);
        uart_busy = 1'b1;
        n = 0;
        while (send && n < 10) begin
            @(negedge clk_xtal);
            n++;
        end
        checkOutput({tag, "_ack"}, {31'd0, send}, 32'd0);
        repeat (3) @(negedge clk_xtal);
        uart_busy = 1'b0;
    endtask

    function automatic logic [7:0] seqByte(input int i);
        return 8'((i * 7 + 3) & 8'hFF);
    endfunction

    initial begin
        int snap;
        rst_n     = 1'b0;
        clr       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        uart_busy = 1'b0;
        repeat (3) @(negedge clk_xtal);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_send", {31'd0, send}, 32'd0);
        checkOutput("rst_data", {24'd0, DataOut}, 32'h00);
        checkOutput("rst_count", {27'd0, count}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);

        $display("[TB] single byte");
        snap = pulses;
        applyStimulus(1'b1, 8'hA5);
        checkOutput("s1_count1", {27'd0, count}, 32'd1);
        checkOutput("s1_send_pre", {31'd0, send}, 32'd0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_req", {31'd0, send}, 32'd1);
        checkOutput("s1_data", {24'd0, DataOut}, 32'hA5);
        checkOutput("s1_count0", {27'd0, count}, 32'd0);
        checkOutput("s1_empty", {31'd0, empty}, 32'd1);
        repeat (9) applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_hold", {31'd0, send}, 32'd1);
        uart_busy = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_b1", {31'd0, send}, 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_b2", {31'd0, send}, 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_ack", {31'd0, send}, 32'd0);
        repeat (47) applyStimulus(1'b0, 8'h00);
        checkOutput("s1_send_busy", {31'd0, send}, 32'd0);
        uart_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("s1_send_tail%0d", k), {31'd0, send}, 32'd0);
        end
        checkOutput("s1_empty_end", {31'd0, empty}, 32'd1);
        checkOutput("s1_data_end", {24'd0, DataOut}, 32'hA5);
        checkOutput("s1_pulses", pulses - snap, 32'd1);

        $display("[TB] fill and overflow");
        uart_busy = 1'b1;
        repeat (3) @(negedge clk_xtal);
        snap = pulses;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(i));
            if (i == 15) begin
                checkOutput("s2_full16", {31'd0, full}, 32'd1);
                checkOutput("s2_ovf_before", {31'd0, overflow}, 32'd0);
            end
        end
        wr_en = 1'b0;
        checkOutput("s2_ovf", {31'd0, overflow}, 32'd1);
        checkOutput("s2_count", {27'd0, count}, 32'd16);
        checkOutput("s2_full", {31'd0, full}, 32'd1);
        uart_busy = 1'b0;
        for (int i = 0; i < 16; i++) serveOne(8'(i), $sformatf("s2_b%0d", i));
        repeat (30) @(negedge clk_xtal);
        checkOutput("s2_pulses", pulses - snap, 32'd16);
        checkOutput("s2_empty", {31'd0, empty}, 32'd1);
        checkOutput("s2_ovf_sticky", {31'd0, overflow}, 32'd1);
        clr = 1'b1;
        @(negedge clk_xtal);
        clr = 1'b0;
        checkOutput("s2_ovf_clr", {31'd0, overflow}, 32'd0);

        $display("[TB] simultaneous push and pop while full");
        uart_busy = 1'b1;
        repeat (3) @(negedge clk_xtal);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i));
        applyStimulus(1'b0, 8'h00);
        checkOutput("s4_full", {31'd0, full}, 32'd1);
        uart_busy = 1'b0;
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'hEE);
        wr_en = 1'b0;
        checkOutput("s4_count", {27'd0, count}, 32'd16);
        checkOutput("s4_full_kept", {31'd0, full}, 32'd1);
        checkOutput("s4_send", {31'd0, send}, 32'd1);
        checkOutput("s4_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++) serveOne(8'(8'h40 + i), $sformatf("s4_b%0d", i));
        serveOne(8'hEE, "s4_new");
        repeat (20) @(negedge clk_xtal);
        checkOutput("s4_empty", {31'd0, empty}, 32'd1);

        $display("[TB] ordering across pointer wraps");
        snap = pulses;
        fork
            begin
                int i;
                i = 0;
                while (i < 40) begin
                    if (!full) begin
                        applyStimulus(1'b1, seqByte(i));
                        i++;
                    end else begin
                        applyStimulus(1'b0, 8'h00);
                    end
                end
                wr_en = 1'b0;
            end
            begin
                for (int j = 0; j < 40; j++) serveOne(seqByte(j), $sformatf("s3_b%0d", j));
            end
        join
        repeat (20) @(negedge clk_xtal);
        checkOutput("s3_pulses", pulses - snap, 32'd40);
        checkOutput("s3_empty", {31'd0, empty}, 32'd1);

        $display("[TB] flush during request");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i));
        wr_en = 1'b0;
        checkOutput("s5_count5", {27'd0, count}, 32'd5);
        checkOutput("s5_send", {31'd0, send}, 32'd1);
        checkOutput("s5_data", {24'd0, DataOut}, 32'h60);
        snap = pulses;
        clr = 1'b1;
        applyStimulus(1'b1, 8'h77);
        clr   = 1'b0;
        wr_en = 1'b0;
        checkOutput("s5_send_clr", {31'd0, send}, 32'd0);
        checkOutput("s5_count_clr", {27'd0, count}, 32'd0);
        checkOutput("s5_empty_clr", {31'd0, empty}, 32'd1);
        checkOutput("s5_ovf_clr", {31'd0, overflow}, 32'd0);
        checkOutput("s5_data_kept", {24'd0, DataOut}, 32'h60);
        repeat (20) @(negedge clk_xtal);
        checkOutput("s5_no_send", pulses - snap, 32'd0);
        checkOutput("s5_count_end", {27'd0, count}, 32'd0);

        $display("[TB] reset during acknowledge");
        applyStimulus(1'b1, 8'h81);
        applyStimulus(1'b1, 8'h82);
        applyStimulus(1'b0, 8'h00);
        checkOutput("s6_send", {31'd0, send}, 32'd1);
        uart_busy = 1'b1;
        begin
            int n;
            n = 0;
            while (send && n < 10) begin
                @(negedge clk_xtal);
                n++;
            end
        end
        checkOutput("s6_in_ack", {31'd0, send}, 32'd0);
        checkOutput("s6_count1", {27'd0, count}, 32'd1);
        uart_busy = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("s6_rst_send", {31'd0, send}, 32'd0);
        checkOutput("s6_rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("s6_rst_count", {27'd0, count}, 32'd0);
        checkOutput("s6_rst_data", {24'd0, DataOut}, 32'h00);
        repeat (2) @(negedge clk_xtal);
        uart_busy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_xtal);
        applyStimulus(1'b1, 8'h99);
        wr_en = 1'b0;
        serveOne(8'h99, "s6_resume");
        repeat (20) @(negedge clk_xtal);
        checkOutput("s6_empty_end", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
